// File: rtl/fpga_ps_loader.sv
// Passive-serial configuration engine: serialises Z80-written bytes onto DCLK/DATA0
// LSB first, then issues the trailing init clocks and reports load status.
module fpga_ps_loader #(
    parameter int DIV      = 1,
    parameter int TMO_W    = 16,
    parameter int XTRA_CLK = 16
) (
    input  logic       clkin,
    input  logic       coldres_n,
    input  logic       config_n,
    input  logic       status_n,
    input  logic       conf_done,
    input  logic       init_done,
    input  logic       wr_stb,
    input  logic [7:0] wr_d,
    output logic       busy,
    output logic       dclk,
    output logic       data0,
    output logic       st_ready,
    output logic       st_done,
    output logic       st_err,
    output logic       st_ovr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_XCLK  = 3'd4;
    localparam logic [2:0] S_WINIT = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [3:0] DIV_M1  = 4'(DIV - 1);
    localparam logic [7:0] XTRA_M1 = 8'(XTRA_CLK - 1);

    logic [1:0] cfg_q, sts_q, cdn_q, idn_q;
    logic       config_n_s, status_n_s, conf_done_s, init_done_s;

    always_ff @(posedge clkin or negedge coldres_n) begin
        if (!coldres_n) begin
            cfg_q <= '0;
            sts_q <= '0;
            cdn_q <= '0;
            idn_q <= '0;
        end else begin
            cfg_q <= {cfg_q[0], config_n};
            sts_q <= {sts_q[0], status_n};
            cdn_q <= {cdn_q[0], conf_done};
            idn_q <= {idn_q[0], init_done};
        end
    end

    assign config_n_s  = cfg_q[1];
    assign status_n_s  = sts_q[1];
    assign conf_done_s = cdn_q[1];
    assign init_done_s = idn_q[1];

    logic [2:0]       state_q, state_d;
    logic [7:0]       buf_q, buf_d, shf_q, shf_d, xcnt_q, xcnt_d;
    logic             busy_q, busy_d, hi_q, hi_d, dclk_q, dclk_d, data0_q, data0_d;
    logic             ovr_q, ovr_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       ph_q, ph_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ph_end, drain, discard;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        busy_d  = busy_q;
        shf_d   = shf_q;
        bit_d   = bit_q;
        ph_d    = ph_q;
        hi_d    = hi_q;
        xcnt_d  = xcnt_q;
        tmo_d   = tmo_q;
        dclk_d  = dclk_q;
        data0_d = data0_q;
        ovr_d   = ovr_q;
        drain   = 1'b0;
        discard = 1'b0;
        ph_end  = (ph_q == DIV_M1);

        case (state_q)
            S_IDLE: begin
                dclk_d  = 1'b0;
                data0_d = 1'b1;
                if (config_n_s) begin
                    state_d = S_WAIT;
                    tmo_d   = '0;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (status_n_s)  state_d = S_LOAD;
                else if (&tmo_q) state_d = S_ERR;
            end
            S_LOAD: begin
                ph_d  = '0;
                hi_d  = 1'b0;
                bit_d = '0;
                if (conf_done_s) begin
                    state_d = S_XCLK;
                    xcnt_d  = '0;
                    data0_d = 1'b1;
                    dclk_d  = 1'b0;
                    discard = 1'b1;
                end else if (busy_q) begin
                    state_d = S_SHIFT;
                    drain   = 1'b1;
                    shf_d   = buf_q;
                    data0_d = buf_q[0];
                    dclk_d  = 1'b0;
                end
            end
            S_SHIFT: begin
                if (!ph_end) begin
                    ph_d = ph_q + 1'b1;
                end else begin
                    ph_d = '0;
                    if (!hi_q) begin
                        hi_d   = 1'b1;
                        dclk_d = 1'b1;
                    end else begin
                        hi_d   = 1'b0;
                        dclk_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            bit_d   = bit_q + 3'd1;
                            data0_d = shf_q[3'(bit_q + 3'd1)];
                        end else begin
                            bit_d = '0;
                            // End of byte: chain straight into the buffered byte with no gap.
                            if (conf_done_s) begin
                                state_d = S_XCLK;
                                xcnt_d  = '0;
                                data0_d = 1'b1;
                                discard = 1'b1;
                            end else if (busy_q) begin
                                drain   = 1'b1;
                                shf_d   = buf_q;
                                data0_d = buf_q[0];
                            end else begin
                                state_d = S_LOAD;
                                data0_d = 1'b1;
                            end
                        end
                    end
                end
            end
            S_XCLK: begin
                data0_d = 1'b1;
                if (!ph_end) begin
                    ph_d = ph_q + 1'b1;
                end else begin
                    ph_d = '0;
                    if (!hi_q) begin
                        hi_d   = 1'b1;
                        dclk_d = 1'b1;
                    end else begin
                        hi_d   = 1'b0;
                        dclk_d = 1'b0;
                        if (xcnt_q == XTRA_M1) state_d = S_WINIT;
                        else                   xcnt_d  = xcnt_q + 8'd1;
                    end
                end
            end
            S_WINIT: begin
                dclk_d = 1'b0;
                if (init_done_s) state_d = S_DONE;
            end
            default: begin
                dclk_d  = 1'b0;
                data0_d = 1'b1;
            end
        endcase

        // A write landing on the draining edge refills the buffer instead of overrunning.
        if (wr_stb && (state_q == S_LOAD || state_q == S_SHIFT)) begin
            if (!busy_q || drain) begin
                buf_d  = wr_d;
                busy_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (drain) begin
            busy_d = 1'b0;
        end

        if (discard) begin
            busy_d = 1'b0;
            buf_d  = '0;
        end

        if (!status_n_s && (state_q == S_LOAD || state_q == S_SHIFT ||
                            state_q == S_XCLK || state_q == S_WINIT)) begin
            state_d = S_ERR;
            dclk_d  = 1'b0;
            data0_d = 1'b1;
            busy_d  = 1'b0;
            buf_d   = '0;
            ph_d    = '0;
            hi_d    = 1'b0;
            bit_d   = '0;
        end

        if (!config_n_s) begin
            state_d = S_IDLE;
            buf_d   = '0;
            busy_d  = 1'b0;
            shf_d   = '0;
            bit_d   = '0;
            ph_d    = '0;
            hi_d    = 1'b0;
            xcnt_d  = '0;
            tmo_d   = '0;
            ovr_d   = 1'b0;
            dclk_d  = 1'b0;
            data0_d = 1'b1;
        end
    end

    logic st_ready_q, st_done_q, st_err_q;

    always_ff @(posedge clkin or negedge coldres_n) begin
        if (!coldres_n) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            busy_q     <= 1'b0;
            shf_q      <= '0;
            bit_q      <= '0;
            ph_q       <= '0;
            hi_q       <= 1'b0;
            xcnt_q     <= '0;
            tmo_q      <= '0;
            dclk_q     <= 1'b0;
            data0_q    <= 1'b1;
            ovr_q      <= 1'b0;
            st_ready_q <= 1'b0;
            st_done_q  <= 1'b0;
            st_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            busy_q     <= busy_d;
            shf_q      <= shf_d;
            bit_q      <= bit_d;
            ph_q       <= ph_d;
            hi_q       <= hi_d;
            xcnt_q     <= xcnt_d;
            tmo_q      <= tmo_d;
            dclk_q     <= dclk_d;
            data0_q    <= data0_d;
            ovr_q      <= ovr_d;
            st_ready_q <= (state_d == S_LOAD);
            st_done_q  <= (state_d == S_DONE);
            st_err_q   <= (state_d == S_ERR);
        end
    end

    assign busy     = busy_q;
    assign dclk     = dclk_q;
    assign data0    = data0_q;
    assign st_ready = st_ready_q;
    assign st_done  = st_done_q;
    assign st_err   = st_err_q;
    assign st_ovr   = ovr_q;

endmodule

// File: doc/fpga_ps_loader.md
Name: fpga_ps_loader

Overview:
- Passive-serial configuration engine for the ACEX1K, directly downstream of the GS CPLD's nCONFIG/status port logic.
- Takes configuration bytes written by the Z80 as single-cycle strobes and serialises them onto DCLK/DATA0, LSB first.
- Monitors nSTATUS, CONF_DONE and INIT_DONE, drives the trailing initialisation clocks, and reports ready/done/error/overrun status back to the port logic.

Parameters:
- DIV, 1: DCLK half-period in clkin cycles, 1..15.
- TMO_W, 16: width of the nSTATUS-release timeout counter; timeout = 2^TMO_W clkin cycles.
- XTRA_CLK, 16: number of DCLK pulses sent after CONF_DONE rises, 1..255.

Ports:
- clkin input 1: Z80-domain clock; the only clock.
- coldres_n input 1: asynchronous active-low reset.
- config_n input 1: nCONFIG value from the port register; asynchronous, synchronised internally.
- status_n input 1: FPGA nSTATUS; asynchronous, synchronised internally.
- conf_done input 1: FPGA CONF_DONE; asynchronous, synchronised internally.
- init_done input 1: FPGA INIT_DONE; asynchronous, synchronised internally.
- wr_stb input 1: one-cycle byte-write strobe, synchronous to clkin.
- wr_d input 8: byte qualified by wr_stb.
- busy output 1: holding buffer full; the writer must wait.
- dclk output 1: FPGA DCLK.
- data0 output 1: FPGA DATA0.
- st_ready output 1: bytes are accepted (state LOAD).
- st_done output 1: configuration complete and INIT_DONE seen.
- st_err output 1: nSTATUS error or timeout.
- st_ovr output 1: a byte was dropped while busy (sticky).

Behaviour:
- Synchronisers:
  - config_n, status_n, conf_done and init_done each pass through 2 flops. The synchronised versions are *_s.
  - The synchronisers reset to config_n=0, status_n=0, conf_done=0, init_done=0.
  - Every reaction to these inputs occurs 2–3 clkin cycles after the pin changes.
- Reset (coldres_n=0, asynchronous):
  - state=IDLE, dclk=0, data0=1, busy=0, st_ready=0, st_done=0, st_err=0, st_ovr=0.
  - Holding buffer and shift register cleared.
- config_n_s=0 in any state:
  - State goes to IDLE on the next edge.
  - Buffer, shifter, counters and st_ovr are cleared. dclk=0, data0=1.
  - This is the only exit from ERR and DONE.
- States:
  - IDLE: leave when config_n_s=1 -> WAIT_ST; timeout counter cleared.
  - WAIT_ST: timeout counter increments every cycle.
    - status_n_s=1 -> LOAD.
    - Counter reaches all-ones -> ERR.
  - LOAD: st_ready=1.
    - A full buffer moves into the shifter on the next edge -> SHIFT.
    - conf_done_s=1 with the shifter idle -> XCLK; buffer discarded, busy=0.
  - SHIFT: sends 8 bits, LSB first.
    - Each bit: data0=bit and dclk=0 for DIV cycles, then dclk=1 for DIV cycles. data0 is held through the high phase.
    - One byte takes 16*DIV cycles.
    - After the last high phase:
      - if the buffer is full and conf_done_s=0, the next byte loads with zero gap: the next cycle is bit0 with dclk low;
      - otherwise return to LOAD.
    - conf_done_s rising mid-byte: the current byte completes, then -> XCLK.
  - XCLK: data0=1. Sends XTRA_CLK full DCLK pulses at the same timing, then -> WAIT_INIT.
  - WAIT_INIT: dclk=0. init_done_s=1 -> DONE.
  - DONE: st_done=1. wr_stb is ignored.
  - ERR: st_err=1, dclk=0, data0=1. wr_stb is ignored.
  - From LOAD, SHIFT, XCLK or WAIT_INIT: status_n_s=0 -> ERR on the next edge, aborting any byte in progress.
- Byte buffer (1 deep):
  - wr_stb with busy=0 in LOAD or SHIFT: the byte is captured and busy=1 on the next edge.
  - wr_stb with busy=1: the byte is dropped and st_ovr=1.
  - wr_stb in any other state: ignored, no flag set.
  - wr_stb on the same edge the buffer empties into the shifter: the byte is accepted, busy stays 1, no overrun.
- Counters:
  - Bit counter: 3 bits. Phase counter: 4 bits, wraps at DIV-1. Extra-clock counter: 8 bits.
  - Timeout counter: TMO_W bits; its all-ones value is the terminal count.
- All outputs are registered.

Test Plan:
- Reset, config_n=1, status_n=1 after 5 cycles, DIV=1:
  - st_ready=1 by 3 cycles after status_n rises.
  - Write 0xA5: data0 sequence 1,0,1,0,0,1,0,1 over 16 cycles, 8 dclk rising edges, then st_ready remains 1.
- Back-to-back 0x01 then 0xFF, second written during the first:
  - Zero gap between bytes; 16 dclk edges total; busy high from the 2nd write until the 0xFF load.
- Third write while busy=1:
  - Byte dropped, st_ovr=1, first two bytes shift correctly.
  - config_n pulse low clears st_ovr.
- conf_done rises during bit 3 of a byte, XTRA_CLK=16:
  - Byte finishes, then exactly 16 dclk pulses with data0=1.
  - Then init_done=1 -> st_done=1 within 3 cycles.
- status_n falls mid-byte:
  - dclk=0 and st_err=1 within 3 cycles; writes ignored.
  - config_n low then high restarts from WAIT_ST with st_err=0.
- TMO_W=4, status_n held 0 after config_n=1:
  - st_err=1 16 cycles after WAIT_ST entry.
  - coldres_n asserted mid-SHIFT forces all outputs to reset values immediately.
